wb_bus_dispatch: RTL

//  Parametrised Wishbone (classic) interconnect between the SPI command master and N register

---
 rtl/wb_bus_dispatch_if.sv | 36 +++
 rtl/wb_bus_dispatch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_bus_dispatch_if.sv
// Wishbone bundle for wb_bus_dispatch: the upstream (SPI command master) side
// and the shared/one-hot fan-out towards NUM_SLAVES register slaves.
interface wb_bus_dispatch_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 7,
  parameter int SLV_ADR_W  = 4,
  parameter int DAT_W      = 32
);
  logic                        wb_cyc_i;
  logic                        wb_stb_i;
  logic                        wb_we_i;
  logic [ADR_W-1:0]            wb_adr_i;
  logic [DAT_W-1:0]            wb_dat_i;
  logic [DAT_W-1:0]            wb_dat_o;
  logic                        wb_ack_o;
  logic [NUM_SLAVES-1:0]       s_cyc_o;
  logic [NUM_SLAVES-1:0]       s_stb_o;
  logic                        s_we_o;
  logic [SLV_ADR_W-1:0]        s_adr_o;
  logic [DAT_W-1:0]            s_dat_o;
  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]       s_ack_i;
  logic                        bus_err_o;

  // The dispatcher's view: answers the master, drives the slaves.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, s_dat_i, s_ack_i,
    output wb_dat_o, wb_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, bus_err_o
  );

  // The environment's view: upstream master plus the slave register blocks.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, s_dat_i, s_ack_i,
    input  wb_dat_o, wb_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, bus_err_o
  );
endinterface

// File: rtl/wb_bus_dispatch.sv
// One-outstanding Wishbone classic dispatcher with decode, timeout and error acks.
// Optional error status register at the top select index: WB_DISPATCH_ERRSTAT_EN.
module wb_bus_dispatch #(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 7,
  parameter int SLV_ADR_W  = 4,
  parameter int DAT_W      = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_bus_dispatch_if.slave bus
);
  localparam int SEL_W = ADR_W - SLV_ADR_W;
  localparam logic [SEL_W:0] NUM_SL = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  // UNMAP delays the decode error by one cycle so it lands like a fastest slave ack.
  typedef enum logic [2:0] {IDLE, BUSY, UNMAP, ACK, ERR} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [ADR_W-1:0]    adr_reg;
  logic                we_reg;
  logic [DAT_W-1:0]    dat_reg;
  logic [DAT_W-1:0]    rdata_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic [SEL_W-1:0]    req_sel;
  logic [DAT_W-1:0]    sel_data;
  logic [DAT_W-1:0]    stat_rdata;
  logic [NUM_SLAVES-1:0] hit;
  logic req, req_mapped, req_local, ack_hit, capture, to_fire;

  assign req        = bus.wb_cyc_i & bus.wb_stb_i;
  assign req_sel    = bus.wb_adr_i[ADR_W-1:SLV_ADR_W];
  assign req_mapped = ({1'b0, req_sel} < NUM_SL);

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign hit[gi] = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  assign ack_hit = |(bus.s_ack_i & hit);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (hit[k]) sel_data = sel_data | bus.s_dat_i[k*DAT_W +: DAT_W];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    to_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req) begin
          if (req_local)       state_next = ACK;
          else if (req_mapped) state_next = BUSY;
          else                 state_next = UNMAP;
        end
      end
      BUSY: begin
        // Master abort outranks a same-cycle slave ack; the ack outranks the timeout.
        if (!bus.wb_cyc_i) begin
          state_next = IDLE;
        end else if (ack_hit) begin
          capture    = 1'b1;
          state_next = ACK;
        end else if (cnt_reg == TO_CNT) begin
          to_fire    = 1'b1;
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      UNMAP:   state_next = ERR;
      ACK:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      we_reg    <= 1'b0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req) begin
        adr_reg   <= bus.wb_adr_i;
        we_reg    <= bus.wb_we_i;
        dat_reg   <= bus.wb_dat_i;
        sel_reg   <= req_sel;
        rdata_reg <= bus.wb_we_i ? '0 : stat_rdata;
      end else if (capture) begin
        rdata_reg <= we_reg ? '0 : sel_data;
      end
    end
  end

`ifdef WB_DISPATCH_ERRSTAT_EN
  localparam logic [SEL_W-1:0] LOCAL_SEL = '1;

  logic [15:0]      err_cnt_reg;
  logic             last_to_reg;
  logic [ADR_W-1:0] last_adr_reg;
  logic [31:0]      stat_word;

  assign req_local  = (req_sel == LOCAL_SEL);
  assign stat_word  = {err_cnt_reg, last_to_reg, {(15-ADR_W){1'b0}}, last_adr_reg};
  assign stat_rdata = DAT_W'(stat_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg  <= '0;
      last_to_reg  <= 1'b0;
      last_adr_reg <= '0;
    end else if (state_reg == IDLE && req && req_local && bus.wb_we_i) begin
      err_cnt_reg  <= '0;
      last_to_reg  <= 1'b0;
      last_adr_reg <= '0;
    end else if (to_fire || state_reg == UNMAP) begin
      if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      last_to_reg  <= to_fire;
      last_adr_reg <= adr_reg;
    end
  end
`else
  assign req_local  = 1'b0;
  assign stat_rdata = '0;
`endif

  assign bus.s_cyc_o   = (state_reg == BUSY) ? hit : '0;
  assign bus.s_stb_o   = (state_reg == BUSY) ? hit : '0;
  assign bus.s_we_o    = we_reg;
  assign bus.s_adr_o   = adr_reg[SLV_ADR_W-1:0];
  assign bus.s_dat_o   = dat_reg;
  assign bus.wb_ack_o  = (state_reg == ACK) || (state_reg == ERR);
  assign bus.bus_err_o = (state_reg == ERR);
  assign bus.wb_dat_o  = (state_reg == ERR) ? '1 :
                         (state_reg == ACK) ? rdata_reg : '0;
endmodule
